ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the number of buffered scan codes (power of 2, minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, the maximum clk cycles between PS/2 falling edges inside a frame.
REQ-003 SHALL have port clk  in  1  system clock; all logic in this single domain.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  in  1  raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port nextdata_n  in  1  active-low pop request from the consumer.
REQ-008 SHALL have port data  out  8  scan code at the FIFO head.
REQ-009 SHALL have port ready  out  1  FIFO non-empty; data valid.
REQ-010 SHALL have port overflow  out  1  sticky flag: a good frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  out  1  one-cycle pulse: frame rejected (start, stop, parity or timeout).
REQ-012 SHALL have port busy  out  1  frame reception in progress.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers; a falling edge is sync[2:1]==2'b10, sampling ps2_data's synchronized value in the same cycle.
REQ-014 SHALL use states IDLE, RECV and CHECK; IDLE->RECV on the first falling edge, RECV->CHECK after the 11th bit, CHECK->IDLE next cycle.
REQ-015 SHALL shift bits LSB first into an 11-bit register using a 4-bit counter 0..10; frame = start(0), d[7:0], odd parity, stop(1).
REQ-016 SHALL accept a frame in CHECK only if start==0, stop==1 and XOR(d[7:0], parity)==1; otherwise pulse frame_err, discard it, and push nothing.
REQ-017 SHALL count clk cycles since the last falling edge while in RECV; when the count reaches TIMEOUT_CYC, discard the partial frame, pulse frame_err, and return to IDLE.
REQ-018 SHALL push an accepted byte in the CHECK cycle; ready SHALL rise the following cycle; push-to-ready latency 1 cycle.
REQ-019 SHALL pop one entry on every clk edge where nextdata_n==0 and ready==1; holding nextdata_n low pops one entry per cycle.
REQ-020 SHALL ignore a pop when the FIFO is empty; no pointer change, no error.
REQ-021 SHALL drive data combinationally from the head entry; its value is don't-care while ready==0.
REQ-022 SHALL drop the byte and set overflow when a push arrives with the FIFO full and no pop that cycle.
REQ-023 SHALL perform both operations when a push and a pop occur in the same cycle, full or not; occupancy is unchanged and overflow is not set.
REQ-024 SHALL clear overflow on any successful pop; a same-cycle set has priority over the clear.
REQ-025 SHALL use pointers of width log2(FIFO_DEPTH)+1 that wrap modulo 2*FIFO_DEPTH; full/empty are derived from the MSB and the index bits.
REQ-026 SHALL drive busy high exactly while the state is RECV or CHECK.

Reset
REQ-027 SHALL, on rst, asynchronously set state=IDLE, counters=0, pointers=0, synchronizers=1, ready=0, overflow=0, frame_err=0, busy=0.
REQ-028 SHALL abandon any frame in progress on reset and not push it; after rst falls, reception restarts at the next start bit.

Structure
REQ-029 SHALL take FRAME_BITS=11, the state enumeration and the default FIFO_DEPTH/TIMEOUT_CYC from shared package ps2_pkg.
REQ-030 SHALL implement storage as one sub-module sync_fifo (push/pop/full/empty/head); the frame FSM stays in ps2_rx_fifo.

Verification
REQ-031 SHALL check: frame for 0x1C with parity 0 -> ready=1 one cycle after CHECK, data=0x1C; one pop -> ready=0.
REQ-032 SHALL check: frame 0x1C with parity bit 1 -> frame_err pulses once, ready stays 0.
REQ-033 SHALL check, with TIMEOUT_CYC=100: send 5 bits, then stop -> frame_err at cycle 100 after the last edge, busy=0; a following good 0xF0 frame -> data=0xF0.
REQ-034 SHALL check, with FIFO_DEPTH=8: 9 good frames, no pops -> 8 entries 0x01..0x08 read in order, 9th dropped, overflow=1 until the first pop.
REQ-035 SHALL check: FIFO full while pop and push coincide -> no overflow, occupancy stays 8, new byte read last.
REQ-036 SHALL check: rst asserted after bit 6 of a frame -> all outputs 0 immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame layout, FSM states, defaults.
package ps2_pkg;

  localparam int unsigned FRAME_BITS      = 11;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // Bit 0 is the first bit on the wire (start bit).
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic logic frame_ok(input ps2_frame_t f);
    return (f.start == 1'b0) && (f.stop == 1'b1) && ((^f.data ^ f.parity) == 1'b1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is read combinationally.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames,
// validates them and buffers accepted scan codes in a FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  rx_state_e     state_q, state_nx;
  ps2_frame_t    frame_q, frame_nx;
  logic [3:0]    bit_cnt_q, bit_cnt_nx;
  logic [TW-1:0] to_cnt_q, to_cnt_nx;
  logic          frame_err_nx;
  logic          busy_nx;
  logic          fall_c;
  logic          push_c;
  logic          pop_c;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  assign fall_c = (clk_sync[2:1] == 2'b10);

  // Frame FSM: next state, shift register, counters and error pulse.
  always_comb begin
    state_nx     = state_q;
    frame_nx     = frame_q;
    bit_cnt_nx   = bit_cnt_q;
    to_cnt_nx    = '0;
    frame_err_nx = 1'b0;
    push_c       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_nx = '0;
        if (fall_c) begin
          frame_nx   = ps2_frame_t'({data_sync[2], frame_q[FRAME_BITS-1:1]});
          bit_cnt_nx = 4'd1;
          state_nx   = RECV;
        end
      end
      RECV: begin
        if (fall_c) begin
          frame_nx = ps2_frame_t'({data_sync[2], frame_q[FRAME_BITS-1:1]});
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            bit_cnt_nx = '0;
            state_nx   = CHECK;
          end else begin
            bit_cnt_nx = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          // Keyboard stalled mid-frame: drop the partial frame.
          bit_cnt_nx   = '0;
          frame_err_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          to_cnt_nx = to_cnt_q + TW'(1);
        end
      end
      CHECK: begin
        state_nx = IDLE;
        if (frame_ok(frame_q)) push_c       = 1'b1;
        else                   frame_err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nx;
      frame_q   <= frame_nx;
      bit_cnt_q <= bit_cnt_nx;
      to_cnt_q  <= to_cnt_nx;
      frame_err <= frame_err_nx;
      busy      <= busy_nx;
    end
  end

  assign ready = !fifo_empty;
  assign pop_c = !nextdata_n && ready;

  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overflow <= 1'b0;
    else if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
    else if (pop_c)                       overflow <= 1'b0;
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (frame_q.data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (data)
  );

endmodule
